// File: rtl/soc_pkg.sv
// Shared SoC constants: datapath width, register address width and
// the writeback source selects used by decode, regfile and writeback.
package soc_pkg;

    localparam int DATA_W     = 19;
    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_ILL  = 2'b11;

endpackage

// File: rtl/wb_acc_fifo.sv
// Accelerator result queue: synchronous FIFO of {rd, data} entries
// with registered full/empty/level flags.
module wb_acc_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PTR_W'(1);
            if (pop_i)  rd_q <= rd_q + PTR_W'(1);
            if (push_i && !pop_i)
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop_i && !push_i)
                cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: arbitrates MEM/WB against queued accelerator results
// and drives the regfile write port from registered outputs.
module writeback_arbiter #(
    parameter int DATA_W         = soc_pkg::DATA_W,
    parameter int ADDR_W         = soc_pkg::REG_ADDR_W,
    parameter int ACC_FIFO_DEPTH = 2,
    parameter int ACC_STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wb_valid,
    input  logic [ADDR_W-1:0]                 wb_rd,
    input  logic [1:0]                        wb_sel,
    input  logic [DATA_W-1:0]                 alu_result,
    input  logic [DATA_W-1:0]                 load_data,
    input  logic [DATA_W-1:0]                 link_data,
    output logic                              wb_stall,
    input  logic                              acc_valid,
    output logic                              acc_ready,
    input  logic [ADDR_W-1:0]                 acc_rd,
    input  logic [DATA_W-1:0]                 acc_data,
    output logic                              reg_write,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic [DATA_W-1:0]                 wb_data,
    output logic [$clog2(ACC_FIFO_DEPTH):0]   acc_level,
    output logic                              wb_sel_err
);

    import soc_pkg::*;

    localparam int CNT_W = $clog2(ACC_STARVE_MAX + 1);

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     forced;
    logic [ADDR_W-1:0]        head_rd;
    logic [DATA_W-1:0]        head_data;
    logic [DATA_W-1:0]        pipe_data;
    logic [CNT_W-1:0]         starve_q, starve_d;
    logic                     reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]        wb_data_q, wb_data_d;
    logic                     sel_err_q, sel_err_d;

    wb_acc_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (ACC_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({acc_rd, acc_data}),
        .rdata_o ({head_rd, head_data}),
        .full_o  (full),
        .empty_o (empty),
        .level_o (acc_level)
    );

    assign acc_ready = !full && !rst;
    assign push      = acc_valid && acc_ready;
    assign forced    = !rst && !empty && wb_valid
                     && (starve_q == CNT_W'(ACC_STARVE_MAX));
    assign pop       = !rst && !empty && (forced || !wb_valid);
    assign wb_stall  = forced;

    always_comb begin
        case (wb_sel)
            WB_SEL_LOAD: pipe_data = load_data;
            WB_SEL_LINK: pipe_data = link_data;
            default:     pipe_data = alu_result;
        endcase
    end

    always_comb begin
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        wb_data_d   = wb_data_q;
        sel_err_d   = sel_err_q;
        starve_d    = starve_q;
        if (pop) begin
            reg_write_d = |head_rd;
            rd_addr_d   = head_rd;
            wb_data_d   = head_data;
        end else if (wb_valid) begin
            if (wb_sel == WB_SEL_ILL) begin
                sel_err_d = 1'b1;
            end else begin
                reg_write_d = |wb_rd;
                rd_addr_d   = wb_rd;
                wb_data_d   = pipe_data;
            end
        end
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != CNT_W'(ACC_STARVE_MAX))
            starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            wb_data_q   <= '0;
            sel_err_q   <= 1'b0;
            starve_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            wb_data_q   <= wb_data_d;
            sel_err_q   <= sel_err_d;
            starve_q    <= starve_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign rd_addr    = rd_addr_q;
    assign wb_data    = wb_data_q;
    assign wb_sel_err = sel_err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter driving a small
// regfile; a queue-based reference model predicts every output.
module tb_writeback_arbiter;

    localparam int DW    = 19;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [1:0]    wb_sel;
    logic [DW-1:0] alu_result, load_data, link_data;
    logic          wb_stall;
    logic          acc_valid, acc_ready;
    logic [AW-1:0] acc_rd;
    logic [DW-1:0] acc_data;
    logic          reg_write;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wb_data;
    logic [1:0]    acc_level;
    logic          wb_sel_err;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA_W(DW), .ADDR_W(AW),
        .ACC_FIFO_DEPTH(DEPTH), .ACC_STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .alu_result(alu_result), .load_data(load_data),
        .link_data(link_data), .wb_stall(wb_stall),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_rd(acc_rd), .acc_data(acc_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .wb_data(wb_data),
        .acc_level(acc_level), .wb_sel_err(wb_sel_err)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          accq[$];
    ent_t          offers[$];
    int            starve = 0;
    logic          exp_err = 1'b0;
    logic [DW-1:0] rf [8];
    logic          was_stalled = 1'b0;
    int            stall_idx;
    int            passes = 0;
    int            total = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic drive_acc();
        acc_valid = (offers.size() > 0);
        if (offers.size() > 0) begin
            acc_rd   = offers[0].rd;
            acc_data = offers[0].d;
        end
    endtask

    // One clock: predict from the queue model, check before and after the edge.
    task automatic step();
        bit            rdy, frc, take, psh, r, we;
        logic [AW-1:0] erd;
        logic [DW-1:0] ed;
        ent_t          e;
        r    = rst;
        rdy  = !r && accq.size() < DEPTH;
        frc  = !r && accq.size() > 0 && wb_valid && starve == SMAX;
        take = !r && accq.size() > 0 && (frc || !wb_valid);
        psh  = acc_valid && rdy;
        we   = 1'b0;
        erd  = '0;
        ed   = '0;
        #1;
        chk("acc_ready", 32'(acc_ready), 32'(rdy));
        chk("wb_stall", 32'(wb_stall), 32'(frc));
        chk("acc_level", 32'(acc_level), 32'(accq.size()));
        was_stalled = wb_stall;
        if (r) begin
            accq.delete();
            starve  = 0;
            exp_err = 1'b0;
        end else begin
            if (accq.size() == 0 || take) starve = 0;
            else starve++;
            if (take) begin
                e   = accq.pop_front();
                we  = (e.rd != 0);
                erd = e.rd;
                ed  = e.d;
            end else if (wb_valid) begin
                if (wb_sel == 2'b11) exp_err = 1'b1;
                else begin
                    we  = (wb_rd != 0);
                    erd = wb_rd;
                    ed  = (wb_sel == 2'b00) ? alu_result :
                          (wb_sel == 2'b01) ? load_data : link_data;
                end
            end
            if (psh) accq.push_back('{acc_rd, acc_data});
        end
        if (psh && offers.size() > 0) void'(offers.pop_front());
        @(posedge clk);
        #1;
        chk("reg_write", 32'(reg_write), 32'(we));
        chk("wb_sel_err", 32'(wb_sel_err), 32'(exp_err));
        if (we || r) begin
            chk("rd_addr", 32'(rd_addr), 32'(erd));
            chk("wb_data", 32'(wb_data), 32'(ed));
        end
        if (reg_write === 1'b1) rf[rd_addr] = wb_data;
        drive_acc();
    endtask

    task automatic pipe(bit v, logic [AW-1:0] rd, logic [1:0] sel,
                        logic [DW-1:0] val);
        wb_valid   = v;
        wb_rd      = rd;
        wb_sel     = sel;
        alu_result = val;
        load_data  = val ^ 19'h1_2345;
        link_data  = val + 19'd1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        rst = 1'b1;
        acc_valid = 1'b0;
        acc_rd = '0;
        acc_data = '0;
        pipe(1'b0, '0, 2'b00, '0);
        @(posedge clk);
        #1;

        // Reset held two cycles, then release with an idle pipeline.
        step();
        step();
        rst = 1'b0;
        step();

        // ALU write to r1, readable through the regfile.
        pipe(1'b1, 3'd1, 2'b00, 19'd123);
        step();
        pipe(1'b0, 3'd0, 2'b00, '0);
        step();
        chk("rf_r1", 32'(rf[1]), 32'd123);

        // LOAD to r0 is dropped; LOAD to r2 lands.
        pipe(1'b1, 3'd0, 2'b01, 19'h4_0001 ^ 19'h1_2345);
        step();
        wb_rd = 3'd2;
        step();
        pipe(1'b0, 3'd0, 2'b00, '0);
        step();
        chk("rf_r2", 32'(rf[2]), 32'h4_0001);

        // Starvation: pipeline held busy, one accelerator result queued.
        pipe(1'b1, 3'd5, 2'b00, 19'd11);
        offers.push_back('{3'd3, 19'h7FFFF});
        drive_acc();
        stall_idx = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (was_stalled && stall_idx < 0) stall_idx = i;
        end
        chk("stall_cycle", 32'(stall_idx), 32'd5);
        pipe(1'b0, 3'd0, 2'b00, '0);
        step();
        chk("rf_r3", 32'(rf[3]), 32'h7FFFF);

        // Three offers against a busy pipeline: FIFO fills at two.
        pipe(1'b1, 3'd6, 2'b10, 19'd40);
        offers.push_back('{3'd1, 19'h0_0AAA});
        offers.push_back('{3'd2, 19'h0_0BBB});
        offers.push_back('{3'd4, 19'h0_0CCC});
        drive_acc();
        for (int i = 0; i < 16; i++) step();
        pipe(1'b0, 3'd0, 2'b00, '0);
        for (int i = 0; i < 4; i++) step();
        chk("rf_r4", 32'(rf[4]), 32'h0_0CCC);
        chk("offers_drained", 32'(offers.size()), 32'd0);

        // Illegal select, then reset with two results queued.
        pipe(1'b1, 3'd1, 2'b11, 19'd77);
        step();
        pipe(1'b1, 3'd7, 2'b00, 19'd5);
        offers.push_back('{3'd5, 19'h1_1111});
        offers.push_back('{3'd6, 19'h2_2222});
        drive_acc();
        for (int i = 0; i < 3; i++) step();
        chk("level_before_rst", 32'(acc_level), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pipe(1'b0, 3'd0, 2'b00, '0);
        for (int i = 0; i < 4; i++) step();
        chk("level_after_rst", 32'(acc_level), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!was_stalled)
                pipe($urandom_range(0, 2) != 0, AW'($urandom),
                     ($urandom_range(0, 15) == 0) ? 2'b11
                         : 2'($urandom_range(0, 2)),
                     DW'($urandom));
            if (offers.size() < 2 && $urandom_range(0, 2) == 0)
                offers.push_back('{AW'($urandom), DW'($urandom)});
            drive_acc();
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
